// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/execute sequencer for a small RV32 subset.
// Walks IDLE -> FETCH -> EXEC, parking in HALT on an illegal or misaligned fetch.
module instruction_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pcNext,
    output logic        exec_valid,
    output logic        halted,
    output logic [31:0] retired_count
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_count_q, retired_count_d;

    logic [6:0]  fetch_op;
    logic        fetch_legal;
    logic        fetch_jal;
    logic [31:0] fetch_target;
    logic [31:0] exec_target;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12],
                inst[20], inst[30:21], 1'b0};
    endfunction

    always_comb begin
        fetch_op     = imem_rdata[6:0];
        fetch_jal    = (fetch_op == OP_JAL);
        fetch_legal  = (fetch_op == OP_R) || (fetch_op == OP_I) ||
                       (fetch_op == OP_LUI) || fetch_jal;
        fetch_target = pc_q + j_imm(imem_rdata);
        exec_target  = pc_q + j_imm(instr_q);
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        retired_count_d = retired_count_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    // A misaligned jump is trapped here so pc never moves.
                    if (!fetch_legal ||
                        (fetch_jal && (fetch_target[1:0] != 2'b00)))
                        state_d = S_HALT;
                    else
                        state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d = (instr_q[6:0] == OP_JAL) ? exec_target
                                                : pc_q + 32'd4;
                retired_count_d = retired_count_q + 32'd1;
                state_d         = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            pc_q            <= RESET_PC;
            instr_q         <= NOP;
            retired_count_q <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign imem_req      = (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign pcNext        = pc_q + 32'd4;
    assign instruction   = instr_q;
    assign exec_valid    = (state_q == S_EXEC);
    assign halted        = (state_q == S_HALT);
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: expected EXEC beats are queued
// when a fetch is acknowledged and compared when exec_valid is seen.
module tb_instruction_sequencer;

    logic        clk;
    logic        rst, start, ack;
    logic [31:0] rdata;
    logic        req, exec_valid, halted;
    logic [31:0] addr, instruction, pc, pc_next, retired;

    logic        b_rst, b_start, b_ack;
    logic [31:0] b_rdata;
    logic        b_req, b_exec, b_halted;
    logic [31:0] b_addr, b_instr, b_pc, b_pc_next, b_retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_ret = 32'd0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] instr;
        logic [31:0] ret;
    } exp_t;

    exp_t exp_q[$];

    instruction_sequencer u_a (
        .clk(clk), .reset(rst), .start(start),
        .imem_req(req), .imem_addr(addr),
        .imem_ack(ack), .imem_rdata(rdata),
        .instruction(instruction), .pc(pc), .pcNext(pc_next),
        .exec_valid(exec_valid), .halted(halted),
        .retired_count(retired)
    );

    instruction_sequencer #(.RESET_PC(32'hFFFF_FFFC)) u_b (
        .clk(clk), .reset(b_rst), .start(b_start),
        .imem_req(b_req), .imem_addr(b_addr),
        .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instruction(b_instr), .pc(b_pc), .pcNext(b_pc_next),
        .exec_valid(b_exec), .halted(b_halted),
        .retired_count(b_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exec_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec: pc %h", pc);
            end else begin
                e = exp_q.pop_front();
                chk("exec_pc", pc, e.pc);
                chk("exec_pcnext", pc_next, e.pc_next);
                chk("exec_instr", instruction, e.instr);
                chk("exec_retired", retired, e.ret);
            end
        end
    end

    task automatic serve(input logic [31:0] exp_addr,
                         input logic [31:0] word,
                         input int waits, input logic legal);
        int n = 0;
        while (req !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (req !== 1'b1) begin
            chk("fetch_timeout", {31'd0, req}, 32'd1);
            return;
        end
        chk("fetch_addr", addr, exp_addr);
        for (int i = 0; i < waits; i++) begin
            rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            chk("hold_req", {31'd0, req}, 32'd1);
            chk("hold_addr", addr, exp_addr);
        end
        if (legal) begin
            exp_q.push_back('{exp_addr, exp_addr + 32'd4, word, exp_ret});
            exp_ret++;
        end
        ack   = 1'b1;
        rdata = word;
        @(negedge clk);
        ack   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        chk("req_drop", {31'd0, req}, 32'd0);
        chk("exec_strobe", {31'd0, exec_valid}, {31'd0, legal});
        chk("instr_latched", instruction, word);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ack = 1'b0; rdata = 32'd0;
        b_rst = 1'b1; b_start = 1'b0; b_ack = 1'b0; b_rdata = 32'd0;
        repeat (2) @(negedge clk);

        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0000_0013);
        chk("rst_retired", retired, 32'h0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_exec", {31'd0, exec_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pcnext", pc_next, 32'h4);

        rst = 1'b0; ack = 1'b1; rdata = 32'h0000_0003;
        @(negedge clk);
        chk("idle_ack_instr", instruction, 32'h0000_0013);
        chk("idle_req", {31'd0, req}, 32'd0);
        ack = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(32'h0, 32'h0050_0093, 0, 1'b1);
        @(negedge clk);
        chk("first_pc", pc, 32'h4);
        chk("first_retired", retired, 32'h1);

        serve(32'h04, 32'h0020_81B3, 3, 1'b1);
        serve(32'h08, 32'h1234_52B7, 0, 1'b1);
        serve(32'h0C, 32'h0000_0013, 1, 1'b1);
        serve(32'h10, 32'h0080_00EF, 0, 1'b1);
        serve(32'h18, 32'hFF9F_F06F, 0, 1'b1);
        serve(32'h10, 32'hFF1F_F0EF, 0, 1'b1);
        serve(32'h00, 32'h0000_0013, 0, 1'b1);
        serve(32'h04, 32'h0000_0013, 0, 1'b1);
        serve(32'h08, 32'h0000_0003, 0, 1'b0);

        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_pc", pc, 32'h8);
        start = 1'b1; ack = 1'b1; rdata = 32'h0050_0093;
        repeat (3) @(negedge clk);
        chk("halt_hold_flag", {31'd0, halted}, 32'd1);
        chk("halt_hold_pc", pc, 32'h8);
        chk("halt_hold_instr", instruction, 32'h0000_0003);
        chk("halt_hold_retired", retired, 32'd9);
        chk("halt_req", {31'd0, req}, 32'd0);
        start = 1'b0; ack = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 32'd0;
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_pc", pc, 32'h0);
        chk("unhalt_instr", instruction, 32'h0000_0013);
        chk("unhalt_retired", retired, 32'h0);
        @(negedge clk);
        chk("unhalt_idle_req", {31'd0, req}, 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(32'h0, 32'h0020_006F, 0, 1'b0);
        chk("misjal_halt", {31'd0, halted}, 32'd1);
        chk("misjal_pc", pc, 32'h0);
        chk("misjal_retired", retired, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rstack_req", {31'd0, req}, 32'd1);
        ack = 1'b1; rdata = 32'h0050_0093; rst = 1'b1;
        @(negedge clk);
        ack = 1'b0; rst = 1'b0;
        chk("rstack_req_low", {31'd0, req}, 32'd0);
        chk("rstack_instr", instruction, 32'h0000_0013);
        chk("rstack_retired", retired, 32'h0);
        chk("rstack_exec", {31'd0, exec_valid}, 32'd0);
        @(negedge clk);
        chk("rstack_idle", {31'd0, req}, 32'd0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve(32'h0, 32'h0050_0093, 0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 32'd0;
        chk("rstexec_retired", retired, 32'h0);
        chk("rstexec_pc", pc, 32'h0);
        chk("rstexec_exec", {31'd0, exec_valid}, 32'd0);

        chk("b_rst_pc", b_pc, 32'hFFFF_FFFC);
        chk("b_rst_halted", {31'd0, b_halted}, 32'd0);
        b_rst = 1'b0;
        force u_b.retired_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_b.retired_count_q;
        chk("b_preset", b_retired, 32'hFFFF_FFFF);
        chk("b_pcnext_wrap", b_pc_next, 32'h0);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        chk("b_req", {31'd0, b_req}, 32'd1);
        chk("b_addr", b_addr, 32'hFFFF_FFFC);
        b_ack = 1'b1; b_rdata = 32'h0000_0013;
        @(negedge clk);
        b_ack = 1'b0;
        chk("b_exec", {31'd0, b_exec}, 32'd1);
        chk("b_exec_instr", b_instr, 32'h0000_0013);
        @(negedge clk);
        chk("b_addr_wrap", b_addr, 32'h0);
        chk("b_retired_wrap", b_retired, 32'h0);
        chk("b_refetch", {31'd0, b_req}, 32'd1);

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
